// File: rtl/neuromorphic_axi_regfile.sv
// AXI4-Lite slave register file: NUM_CTRL read/write control registers with byte strobes and
// write pulses, followed by NUM_STAT read-only status words sampled from stat_in.
module neuromorphic_axi_regfile #(
    parameter int          ADDR_W   = 12,
    parameter int          NUM_CTRL = 4,
    parameter int          NUM_STAT = 4,
    parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [NUM_CTRL*32-1:0] ctrl_out,
    output logic [NUM_CTRL-1:0]   ctrl_wr_pulse,
    input  logic [NUM_STAT*32-1:0] stat_in,
    output logic [NUM_STAT-1:0]   stat_rd_pulse
);
    localparam int               IDX_W    = ADDR_W - 2;
    localparam logic [IDX_W-1:0] CTRL_END = IDX_W'(NUM_CTRL);
    localparam logic [1:0]       RESP_OK  = 2'b00;
    localparam logic [1:0]       RESP_ERR = 2'b10;

    // Handshake: a beat transfers on the rising edge where VALID and READY are both high. The
    // master holds VALID and payload until then; BVALID/RVALID and their payload are held here
    // until the BREADY/RREADY edge.

    logic                    ready_en_q;
    logic                    aw_held_q, aw_held_d;
    logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
    logic                    w_held_q, w_held_d;
    logic [31:0]             w_data_q, w_data_d;
    logic [3:0]              w_strb_q, w_strb_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    rvalid_q, rvalid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [NUM_CTRL*32-1:0]  ctrl_q, ctrl_d;
    logic [NUM_CTRL-1:0]     wr_pulse_q, wr_pulse_d;
    logic [NUM_STAT-1:0]     rd_pulse_q, rd_pulse_d;

    logic                    aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]        wr_idx, rd_idx;
    logic [31:0]             wr_data;
    logic [3:0]              wr_strb;
    logic [3:0]              unused_addr_lsb;

    assign unused_addr_lsb = {S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = ready_en_q && !aw_held_q && !bvalid_q;
    assign S_AXI_WREADY  = ready_en_q && !w_held_q && !bvalid_q;
    assign S_AXI_ARREADY = ready_en_q && !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign ctrl_out      = ctrl_q;
    assign ctrl_wr_pulse = wr_pulse_q;
    assign stat_rd_pulse = rd_pulse_q;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    // The second of AW/W to arrive commits on its own edge, taking the other from the hold regs.
    assign commit  = (aw_hs || aw_held_q) && (w_hs || w_held_q);
    assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[ADDR_W-1:2];
    assign wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;
    assign rd_idx  = S_AXI_ARADDR[ADDR_W-1:2];

    always_comb begin
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        ctrl_d     = ctrl_q;
        wr_pulse_d = '0;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[ADDR_W-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (wr_idx < CTRL_END) ? RESP_OK : RESP_ERR;
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    wr_pulse_d[i] = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        if (wr_strb[k]) ctrl_d[32*i+8*k +: 8] = wr_data[8*k +: 8];
                    end
                end
            end
        end
    end

    // Reads see ctrl_q before any same-edge write commit.
    always_comb begin
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        rd_pulse_d = '0;
        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_ERR;
            rdata_d  = '0;
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    rresp_d = RESP_OK;
                    rdata_d = ctrl_q[32*i +: 32];
                end
            end
            for (int j = 0; j < NUM_STAT; j++) begin
                if (rd_idx == IDX_W'(NUM_CTRL + j)) begin
                    rresp_d       = RESP_OK;
                    rdata_d       = stat_in[32*j +: 32];
                    rd_pulse_d[j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OK;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OK;
            rdata_q    <= '0;
            ctrl_q     <= {NUM_CTRL{CTRL_RST}};
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
        end else begin
            ready_en_q <= 1'b1;
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end
endmodule

// File: tb/tb_neuromorphic_axi_regfile.sv
// Bench for neuromorphic_axi_regfile: AXI drivers, B/R response scoreboards, direct checks.
module tb_neuromorphic_axi_regfile;
    localparam int NC = 4;
    localparam int NS = 4;

    logic          clk;
    logic          rst_n;
    logic [11:0]   S_AXI_AWADDR;
    logic          S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0]   S_AXI_WDATA;
    logic [3:0]    S_AXI_WSTRB;
    logic          S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID, S_AXI_BREADY;
    logic [11:0]   S_AXI_ARADDR;
    logic          S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0]   S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID, S_AXI_RREADY;
    logic [NC*32-1:0] ctrl_out;
    logic [NC-1:0] ctrl_wr_pulse;
    logic [NS*32-1:0] stat_in;
    logic [NS-1:0] stat_rd_pulse;

    int n_vec = 0;
    int n_err = 0;
    logic [1:0]  wr_exp_q[$];
    logic [33:0] rd_exp_q[$];
    logic [31:0] exp_ctrl[NC];

    neuromorphic_axi_regfile #(.ADDR_W(12), .NUM_CTRL(NC), .NUM_STAT(NS), .CTRL_RST(32'h0)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .ctrl_out(ctrl_out), .ctrl_wr_pulse(ctrl_wr_pulse),
        .stat_in(stat_in), .stat_rd_pulse(stat_rd_pulse)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        for (int k = 0; k < 4; k++) begin
            if (s[k]) exp_ctrl[idx][8*k +: 8] = d[8*k +: 8];
        end
    endtask

    task automatic check_ctrl(input string tag);
        for (int i = 0; i < NC; i++) check_eq(tag, ctrl_out[32*i +: 32], exp_ctrl[i]);
    endtask

    // drivers
    task automatic send_aw_w(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_done, w_done, aw_now, w_now;
        int cyc;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk);
            aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
            w_now  = S_AXI_WVALID && S_AXI_WREADY;
            cyc++;
            step();
            if (aw_now) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
            if (w_now) begin w_done = 1'b1; S_AXI_WVALID = 1'b0; end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check_eq("aw_w_accepted", {aw_done, w_done}, 2'b11);
    endtask

    task automatic send_aw(input logic [11:0] a);
        logic done;
        int cyc;
        done = 1'b0; cyc = 0;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            done = S_AXI_AWREADY;
            cyc++;
            step();
        end
        S_AXI_AWVALID = 1'b0;
        check_eq("aw_accepted", done, 1'b1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        logic done;
        int cyc;
        done = 1'b0; cyc = 0;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            done = S_AXI_WREADY;
            cyc++;
            step();
        end
        S_AXI_WVALID = 1'b0;
        check_eq("w_accepted", done, 1'b1);
    endtask

    task automatic send_ar(input logic [11:0] a);
        logic done;
        int cyc;
        done = 1'b0; cyc = 0;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            done = S_AXI_ARREADY;
            cyc++;
            step();
        end
        S_AXI_ARVALID = 1'b0;
        check_eq("ar_accepted", done, 1'b1);
    endtask

    // scoreboard: responses compared on the handshake cycle
    always @(negedge clk) begin
        if (S_AXI_BVALID && S_AXI_BREADY) begin
            check_eq("b_expected", wr_exp_q.size() != 0, 1'b1);
            if (wr_exp_q.size() != 0) check_eq("bresp", S_AXI_BRESP, wr_exp_q.pop_front());
        end
        if (S_AXI_RVALID && S_AXI_RREADY) begin
            check_eq("r_expected", rd_exp_q.size() != 0, 1'b1);
            if (rd_exp_q.size() != 0) check_eq("rresp_rdata", {S_AXI_RRESP, S_AXI_RDATA}, rd_exp_q.pop_front());
        end
    end

    initial begin
        int idx;
        logic [31:0] d, st3;
        logic [3:0] s;

        rst_n = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1; stat_in = '0;
        for (int i = 0; i < NC; i++) exp_ctrl[i] = 32'h0;

        // reset state
        repeat (3) step();
        @(negedge clk);
        check_eq("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        check_eq("rst_valids", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}, 6'b0);
        check_eq("rst_rdata", S_AXI_RDATA, 32'h0);
        check_ctrl("rst_ctrl");
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check_eq("post_rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        step();
        rd_exp_q.push_back({2'b00, 32'h0});
        send_ar(12'h000);

        // same-cycle AW+W
        wr_exp_q.push_back(2'b00);
        model_write(1, 32'hDEADBEEF, 4'hF);
        send_aw_w(12'h004, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        check_eq("wr_pulse_ctrl1", ctrl_wr_pulse, 4'b0010);
        check_ctrl("ctrl_after_wr1");
        @(negedge clk);
        check_eq("wr_pulse_clear", ctrl_wr_pulse, 4'b0000);
        step();
        rd_exp_q.push_back({2'b00, 32'hDEADBEEF});
        send_ar(12'h004);

        // W three cycles ahead of AW, response held off
        wr_exp_q.push_back(2'b00);
        model_write(2, 32'hDEADBEEF, 4'hF);
        send_aw_w(12'h008, 32'hDEADBEEF, 4'hF);
        step();
        S_AXI_BREADY = 1'b0;
        send_w(32'h12345678, 4'b0101);
        @(negedge clk);
        check_eq("w_held_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b100);
        step();
        step();
        model_write(2, 32'h12345678, 4'b0101);
        send_aw(12'h008);
        @(negedge clk);
        check_eq("ctrl2_strobed", ctrl_out[95:64], 32'hDE34BE78);
        check_ctrl("ctrl_after_split");
        check_eq("wr_pulse_ctrl2", ctrl_wr_pulse, 4'b0100);
        check_eq("b_pending_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b001);
        repeat (2) begin
            @(negedge clk);
            check_eq("b_stall_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b001);
        end
        step();
        wr_exp_q.push_back(2'b00);
        S_AXI_BREADY = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("b_done_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b110);
        step();

        // status read and status write
        for (int j = 0; j < NS; j++) stat_in[32*j +: 32] = $urandom;
        stat_in[63:32] = 32'h000000A5;
        st3 = stat_in[127:96];
        step();
        rd_exp_q.push_back({2'b00, 32'h000000A5});
        send_ar(12'h014);
        @(negedge clk);
        check_eq("stat_pulse_1", stat_rd_pulse, 4'b0010);
        @(negedge clk);
        check_eq("stat_pulse_clear", stat_rd_pulse, 4'b0000);
        step();
        rd_exp_q.push_back({2'b00, st3});
        send_ar(12'h01C);
        @(negedge clk);
        check_eq("stat_pulse_3", stat_rd_pulse, 4'b1000);
        step();
        wr_exp_q.push_back(2'b10);
        send_aw_w(12'h014, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        check_eq("stat_wr_no_pulse", ctrl_wr_pulse, 4'b0000);
        check_ctrl("stat_wr_no_change");
        step();

        // out-of-range read held, then out-of-range write
        S_AXI_RREADY = 1'b0;
        rd_exp_q.push_back({2'b10, 32'h0});
        send_ar(12'h040);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("oor_r_hold", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RRESP, S_AXI_RDATA}, {1'b1, 1'b0, 2'b10, 32'h0});
            check_eq("oor_no_stat_pulse", stat_rd_pulse, 4'b0000);
        end
        step();
        S_AXI_RREADY = 1'b1;
        step();
        wr_exp_q.push_back(2'b10);
        send_aw_w(12'h040, 32'h5555_AAAA, 4'hF);
        @(negedge clk);
        check_eq("oor_wr_no_pulse", ctrl_wr_pulse, 4'b0000);
        check_ctrl("oor_wr_no_change");
        step();

        // zero strobes still pulse
        wr_exp_q.push_back(2'b00);
        send_aw_w(12'h000, 32'hFFFF_FFFF, 4'h0);
        @(negedge clk);
        check_eq("zero_strb_pulse", ctrl_wr_pulse, 4'b0001);
        check_ctrl("zero_strb_ctrl");
        step();

        // same-edge read and write return the pre-commit value
        rd_exp_q.push_back({2'b00, exp_ctrl[3]});
        wr_exp_q.push_back(2'b00);
        model_write(3, 32'hCAFE_F00D, 4'hF);
        fork
            send_aw_w(12'h00C, 32'hCAFE_F00D, 4'hF);
            send_ar(12'h00C);
        join
        step();

        // random control traffic with read-back
        for (int n = 0; n < 10; n++) begin
            idx = $urandom_range(0, NC - 1);
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            model_write(idx, d, s);
            wr_exp_q.push_back(2'b00);
            send_aw_w(12'(idx * 4), d, s);
            rd_exp_q.push_back({2'b00, exp_ctrl[idx]});
            send_ar(12'(idx * 4 + $urandom_range(0, 3)));
        end

        // reset between AW and W
        send_aw(12'h004);
        rst_n = 1'b0;
        for (int i = 0; i < NC; i++) exp_ctrl[i] = 32'h0;
        @(negedge clk);
        check_eq("midrst_valids", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY}, 3'b000);
        check_ctrl("midrst_ctrl");
        step();
        rst_n = 1'b1;
        step();
        send_w(32'h0BAD_0BAD, 4'hF);
        repeat (3) begin
            @(negedge clk);
            check_eq("midrst_no_commit", {S_AXI_BVALID, ctrl_wr_pulse}, 5'b0);
        end
        step();
        wr_exp_q.push_back(2'b00);
        model_write(1, 32'h0BAD_0BAD, 4'hF);
        send_aw(12'h004);
        @(negedge clk);
        check_eq("midrst_pulse", ctrl_wr_pulse, 4'b0010);
        check_ctrl("midrst_write");
        step();
        rd_exp_q.push_back({2'b00, 32'h0BAD_0BAD});
        send_ar(12'h004);

        repeat (5) step();
        check_eq("b_queue_drained", wr_exp_q.size(), 0);
        check_eq("r_queue_drained", rd_exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
